// File: rtl/shift_reg_5bits_sipo_rx.sv
// shift_reg_5bits_sipo_rx
// Serial-in/parallel-out receiver for the 5-bit left-shift transmitter.
// Bits arrive MSB first; each WIDTH-bit frame becomes one parallel word.
// The word is held in a one-entry valid/ready output buffer.
// A completed word that finds the buffer full is dropped and the sticky
// overrun flag is raised.
//
// Optional feature (macro SIPO_PARITY_EN):
//   When defined, every frame carries an extra even-parity bit after the
//   data bits, and parity_err reports a mismatch on the word in dout.
//   When undefined, frames are WIDTH bits and o_parity_err is tied to 0.
//
// Handshake: o_dout is meaningful while o_dout_valid=1. A word is consumed
// on any rising edge where o_dout_valid=1 and i_out_ready=1. A word that
// completes on that same edge replaces it, so o_dout_valid stays high.
module shift_reg_5bits_sipo_rx #(
    parameter int WIDTH = 5,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    input  logic             i_out_ready,
    input  logic             i_clr_ovr,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_dout_valid,
    output logic             o_overrun,
    output logic             o_busy,
    output logic             o_parity_err,
    output logic [1:0]       o_dbg_state
);

`ifdef SIPO_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t             r_state;
    logic [WIDTH-1:0]   r_shreg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic [WIDTH-1:0]   r_dout;
    logic               r_dout_valid;
    logic               r_overrun;

    // A start strobe always wins over a coincident data bit.
    logic               w_take;
    logic               w_last_data;
    logic [WIDTH-1:0]   w_shift_word;
    logic               w_commit;
    logic [WIDTH-1:0]   w_commit_word;
    logic               w_can_store;

    assign w_take       = i_sin_valid && !i_start;
    assign w_last_data  = (r_state == SHIFT) && w_take &&
                          (r_cnt == CNT_W'(WIDTH - 1));
    assign w_shift_word = {r_shreg[WIDTH-2:0], i_sin};
    assign w_can_store  = !r_dout_valid || i_out_ready;

`ifdef SIPO_PARITY_EN
    // The full word already sits in the shift register while the parity
    // bit is being received.
    logic r_parity_err;
    assign w_commit      = (r_state == PARITY) && w_take;
    assign w_commit_word = r_shreg;
`else
    assign w_commit      = w_last_data;
    assign w_commit_word = w_shift_word;
`endif

    // Frame FSM: tracks the position within a frame and assembles the word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= SHIFT;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (i_start) begin
                        r_shreg <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (i_sin_valid) begin
                        r_shreg <= w_shift_word;
                        if (w_last_data) begin
                            r_cnt <= '0;
`ifdef SIPO_PARITY_EN
                            r_state <= PARITY;
                            r_busy  <= 1'b1;
`else
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef SIPO_PARITY_EN
                PARITY: begin
                    if (i_start) begin
                        r_state <= SHIFT;
                        r_shreg <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end else if (i_sin_valid) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // One-entry output buffer: commit, consume and sticky overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            // Clear first so a drop on the same edge takes precedence.
            if (i_clr_ovr) begin
                r_overrun <= 1'b0;
            end
            if (w_commit) begin
                if (w_can_store) begin
                    r_dout       <= w_commit_word;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_dout_valid && i_out_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // Parity flag travels with dout; a dropped word leaves it untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else if (w_commit && w_can_store) begin
            r_parity_err <= (^r_shreg) ^ i_sin;
        end
    end
    assign o_parity_err = r_parity_err;
`else
    assign o_parity_err = 1'b0;
`endif

    assign o_dout       = r_dout;
    assign o_dout_valid = r_dout_valid;
    assign o_overrun    = r_overrun;
    assign o_busy       = r_busy;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_shift_reg_5bits_sipo_rx.sv
// Testbench for shift_reg_5bits_sipo_rx: a table of per-edge vectors with
// hand-computed expectations, plus a hand-written asynchronous reset check.
module tb_shift_reg_5bits_sipo_rx;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sin;
  logic       sin_valid;
  logic       out_ready;
  logic       clr_ovr;
  logic [4:0] dout;
  logic       dout_valid;
  logic       overrun;
  logic       busy;
  logic       parity_err;
  logic [1:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       st;
    logic       sin;
    logic       sv;
    logic       rdy;
    logic       clr;
    logic [4:0] dout;
    logic       v;
    logic       ovr;
    logic       busy;
    logic       perr;
  } vec_t;

  vec_t vecs[$];

  shift_reg_5bits_sipo_rx #(.WIDTH(5), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_sin        (sin),
    .i_sin_valid  (sin_valid),
    .i_out_ready  (out_ready),
    .i_clr_ovr    (clr_ovr),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .o_overrun    (overrun),
    .o_busy       (busy),
    .o_parity_err (parity_err),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add_row(input string nm, input logic st, input logic s, input logic sv,
                         input logic rdy, input logic clr, input logic [4:0] d,
                         input logic v, input logic o, input logic b, input logic p);
    vec_t r;
    r.name = nm; r.st = st; r.sin = s; r.sv = sv; r.rdy = rdy; r.clr = clr;
    r.dout = d; r.v = v; r.ovr = o; r.busy = b; r.perr = p;
    vecs.push_back(r);
  endtask

  // Five data bits MSB first; the first four rows expect the "mid" outputs,
  // the fifth row carries rdy/clr and expects the "end" outputs.
  task automatic add_bits(input string nm, input logic [4:0] bits,
                          input logic [4:0] d_mid, input logic v_mid, input logic o_mid,
                          input logic rdy_end, input logic clr_end,
                          input logic [4:0] d_end, input logic v_end, input logic o_end,
                          input logic b_end, input logic p_end);
    for (int i = 4; i >= 1; i--)
      add_row($sformatf("%s_b%0d", nm, 4 - i), 1'b0, bits[i], 1'b1, 1'b0, 1'b0,
              d_mid, v_mid, o_mid, 1'b1, 1'b0);
    add_row($sformatf("%s_b4", nm), 1'b0, bits[0], 1'b1, rdy_end, clr_end,
            d_end, v_end, o_end, b_end, p_end);
  endtask

  // driver: one vector per rising edge, checked 1 ns after the edge
  task automatic apply(input vec_t r);
    @(negedge clk);
    start = r.st; sin = r.sin; sin_valid = r.sv; out_ready = r.rdy; clr_ovr = r.clr;
    @(posedge clk);
    #1;
    chk({r.name, ".dout"},  16'(dout),       16'(r.dout));
    chk({r.name, ".valid"}, 16'(dout_valid), 16'(r.v));
    chk({r.name, ".ovr"},   16'(overrun),    16'(r.ovr));
    chk({r.name, ".busy"},  16'(busy),       16'(r.busy));
    chk({r.name, ".perr"},  16'(parity_err), 16'(r.perr));
  endtask

  initial begin
    rst = 1'b1; start = 0; sin = 0; sin_valid = 0; out_ready = 0; clr_ovr = 0;

`ifdef SIPO_PARITY_EN
    add_row("p_start", 1, 0, 0, 0, 0, 5'h00, 0, 0, 1, 0);
    add_bits("p_ok", 5'b10101, 5'h00, 0, 0, 0, 0, 5'h00, 0, 0, 1, 0);
    add_row("p_ok_par", 0, 1, 1, 0, 0, 5'b10101, 1, 0, 0, 0);
    add_row("p_consume", 0, 0, 0, 1, 0, 5'b10101, 0, 0, 0, 0);
    add_row("p_start2", 1, 0, 0, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_bits("p_bad", 5'b10101, 5'b10101, 0, 0, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("p_bad_par", 0, 0, 1, 0, 0, 5'b10101, 1, 0, 0, 1);
    add_row("p_start3", 1, 0, 0, 0, 0, 5'b10101, 1, 0, 1, 1);
`else
    // IDLE ignores data bits
    add_row("idle_ign", 0, 1, 1, 0, 0, 5'h00, 0, 0, 0, 0);
    // basic frame 10101
    add_row("basic_start", 1, 0, 0, 0, 0, 5'h00, 0, 0, 1, 0);
    add_bits("basic", 5'b10101, 5'h00, 0, 0, 0, 0, 5'b10101, 1, 0, 0, 0);
    add_row("consume", 0, 0, 0, 1, 0, 5'b10101, 0, 0, 0, 0);
    // gapped frame 11111
    add_row("gap_start", 1, 0, 0, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("gap_b0", 0, 1, 1, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("gap_b1", 0, 1, 1, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("gap_idle0", 0, 0, 0, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("gap_idle1", 0, 0, 0, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("gap_b2", 0, 1, 1, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("gap_b3", 0, 1, 1, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("gap_b4", 0, 1, 1, 0, 0, 5'b11111, 1, 0, 0, 0);
    add_row("gap_hs", 0, 0, 0, 1, 0, 5'b11111, 0, 0, 0, 0);
    add_row("gap_hold", 0, 0, 0, 0, 0, 5'b11111, 0, 0, 0, 0);
    // overrun
    add_row("ovr_start1", 1, 0, 0, 0, 0, 5'b11111, 0, 0, 1, 0);
    add_bits("ovr_f1", 5'b10101, 5'b11111, 0, 0, 0, 0, 5'b10101, 1, 0, 0, 0);
    add_row("ovr_start2", 1, 0, 0, 0, 0, 5'b10101, 1, 0, 1, 0);
    add_bits("ovr_f2", 5'b00011, 5'b10101, 1, 0, 0, 0, 5'b10101, 1, 1, 0, 0);
    add_row("ovr_clr", 0, 0, 0, 0, 1, 5'b10101, 1, 0, 0, 0);
    add_row("setwin_start", 1, 0, 0, 0, 0, 5'b10101, 1, 0, 1, 0);
    add_bits("setwin", 5'b11001, 5'b10101, 1, 0, 0, 1, 5'b10101, 1, 1, 0, 0);
    add_row("setwin_clr", 0, 0, 0, 0, 1, 5'b10101, 1, 0, 0, 0);
    // restart mid-frame; the second start carries a bit that must be dropped
    add_row("rs_consume", 0, 0, 0, 1, 0, 5'b10101, 0, 0, 0, 0);
    add_row("rs_start", 1, 0, 0, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("rs_p0", 0, 1, 1, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("rs_p1", 0, 1, 1, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("rs_p2", 0, 1, 1, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_row("rs_restart", 1, 1, 1, 0, 0, 5'b10101, 0, 0, 1, 0);
    add_bits("rs", 5'b00100, 5'b10101, 0, 0, 0, 0, 5'b00100, 1, 0, 0, 0);
    // back-to-back commit with consume on the completing edge
    add_row("b2b_start", 1, 0, 0, 0, 0, 5'b00100, 1, 0, 1, 0);
    add_bits("b2b", 5'b01110, 5'b00100, 1, 0, 1, 0, 5'b01110, 1, 0, 0, 0);
    // open a new frame for the asynchronous reset check
    add_row("ar_start", 1, 0, 0, 0, 0, 5'b01110, 1, 0, 1, 0);
    add_row("ar_b0", 0, 1, 1, 0, 0, 5'b01110, 1, 0, 1, 0);
`endif

    // reset state
    #15;
    rst = 1'b0;
    @(negedge clk);
    chk("rst.dout",  16'(dout),       16'h0);
    chk("rst.valid", 16'(dout_valid), 16'h0);
    chk("rst.ovr",   16'(overrun),    16'h0);
    chk("rst.busy",  16'(busy),       16'h0);
    chk("rst.perr",  16'(parity_err), 16'h0);

    foreach (vecs[i]) apply(vecs[i]);

    // asynchronous reset between edges, mid-frame
    #2;
    rst = 1'b1;
    #1;
    chk("arst.dout",  16'(dout),       16'h0);
    chk("arst.valid", 16'(dout_valid), 16'h0);
    chk("arst.ovr",   16'(overrun),    16'h0);
    chk("arst.busy",  16'(busy),       16'h0);
    chk("arst.perr",  16'(parity_err), 16'h0);
    @(negedge clk);
    rst = 1'b0; start = 0; sin_valid = 0; out_ready = 0; clr_ovr = 0;
    @(posedge clk);
    #1;
    chk("post_arst.busy",  16'(busy),       16'h0);
    chk("post_arst.valid", 16'(dout_valid), 16'h0);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_5bits_sipo_rx.md
Name: shift_reg_5bits_sipo_rx

Overview:
- Serial-in/parallel-out receiver, the far end of the team's 5-bit left-shift transmitter.
- The transmitter sends Q[4] (MSB) first, so this block takes bits MSB-first.
- It assembles each frame of WIDTH bits into a parallel word.
- It presents the word through a valid/ready output buffer and flags overrun when a completed word cannot be stored.

Parameters:
- WIDTH, 5: data bits per frame (legal values 2..16).
- CNT_W, 3: bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  synchronous frame-start strobe; aborts any partial frame.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on this cycle's rising edge.
- out_ready  in  1  consumer accepts dout this cycle.
- clr_ovr  in  1  clears the overrun flag.
- dout  out  WIDTH  assembled word, MSB = first bit received.
- dout_valid  out  1  dout holds an unconsumed word.
- overrun  out  1  sticky: a completed word was dropped.
- busy  out  1  a frame is in progress (state != IDLE).
- parity_err  out  1  parity mismatch on the word in dout; tied 0 without the macro.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; shift register and counter = 0.
  - dout=0, dout_valid=0, overrun=0, busy=0, parity_err=0.
- States: IDLE, SHIFT, and PARITY (PARITY exists only with the macro).
- IDLE:
  - sin and sin_valid are ignored.
  - start=1 -> SHIFT, counter=0, shift register=0.
- SHIFT, on each edge with sin_valid=1:
  - shreg <= {shreg[WIDTH-2:0], sin}; counter increments.
  - With sin_valid=0, the state holds and no bit is taken.
- Frame completion: counter==WIDTH-1 and sin_valid=1.
  - The word is {shreg[WIDTH-2:0], sin}.
  - Without the macro: commit the word on that same edge, then go to IDLE.
  - A new frame needs a new start.
- start while in SHIFT or PARITY:
  - Discard the partial frame; counter=0, shift register=0; stay in or enter SHIFT.
  - start has priority over a coincident sin_valid, and that bit is dropped.
- Commit rules (output buffer, one entry):
  - dout_valid=0, or dout_valid=1 with out_ready=1 this cycle: dout <= word, dout_valid stays/becomes 1.
  - dout_valid=1 with out_ready=0: word dropped, dout unchanged, overrun <= 1.
- Consume: out_ready=1 with dout_valid=1 and no coincident commit -> dout_valid <= 0. dout keeps its last value.
- overrun:
  - Cleared by clr_ovr or rst.
  - If clr_ovr and a new drop happen on the same edge, set wins.
- busy = (state != IDLE), registered with the state.
- Latency: dout_valid rises on the same edge that samples the last frame bit (last data bit, or parity bit with the macro).
- Reset mid-frame: partial data is lost; all outputs return to their reset values immediately.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - After the WIDTH-th data bit, go to PARITY instead of committing.
  - The next sin_valid bit is an even-parity bit over the data.
  - On that edge, commit the word (same commit rules) and go to IDLE.
  - parity_err <= (^word) ^ parity_bit. It is loaded together with dout and shares dout_valid.
  - A dropped word does not change parity_err.
- Not defined:
  - No PARITY state; the frame is WIDTH bits.
  - parity_err is constant 0.

Test Plan:
- Basic frame:
  - Stimulus: rst 15ns; start; sin = 1,0,1,0,1 on consecutive sin_valid cycles; out_ready=0.
  - Response: dout=10101 and dout_valid=1 after the 5th edge; busy=0 afterwards.
- Gapped bits and handshake:
  - Stimulus: frame 11111 with sin_valid dropping low for 2 cycles between bits 2 and 3; then out_ready=1 for 1 cycle.
  - Response: dout=11111 after the 5th valid bit; dout_valid=0 on the edge after the out_ready pulse.
- Overrun:
  - Stimulus: leave 10101 unconsumed; receive 00011 with out_ready=0; pulse clr_ovr.
  - Response: dout stays 10101, overrun=1; overrun=0 after the clr_ovr pulse.
- Restart and async reset:
  - Stimulus: start, 3 bits (1,1,1), start again, then bits 0,0,1,0,0.
  - Response: dout=00100, with none of the aborted bits present.
  - Stimulus: assert rst mid-frame between clock edges.
  - Response: all outputs are 0 immediately, before the next edge.
- Back-to-back commit:
  - Stimulus: dout_valid=1 with out_ready=1 on the edge that completes frame 01110.
  - Response: dout=01110, dout_valid stays 1, overrun=0.
- Parity (SIPO_PARITY_EN only):
  - Stimulus: frame 10101 + parity bit 1.
  - Response: parity_err=0.
  - Stimulus: frame 10101 + parity bit 0.
  - Response: parity_err=1; dout=10101 in both cases.
